uart_receiver: RTL and testbench

Serial receive front end between the FPGA_SERIAL_RX pin and the CPU's memory-mapped UART registers. Oversamples the asynchronous 8N1 line with the CPU clock and deserialises frames LSB-first. Presents each byte through a one-entry valid/ready holding register that the CPU's MMIO load path consumes. Flags framing errors and overruns to the CPU status register.

---
 rtl/uart_receiver_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_receiver.sv | 141 ++++++++++++++
 tb/tb_uart_receiver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared 8N1 UART definitions: FSM encodings, frame constants and bit timing.
// Keeping the timing helpers here lets the transmitter reuse the same timing.
package uart_receiver_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam int DATA_BITS = 8;

    function automatic int symbol_edge_time(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int sample_time(input int clk_hz, input int baud);
        return symbol_edge_time(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive front end: oversampling FSM plus a one-entry
// valid/ready holding register with framing-error and overrun pulses.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CPU_CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE      = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int SYM = symbol_edge_time(CPU_CLOCK_FREQ, BAUD_RATE);
    localparam int SMP = sample_time(CPU_CLOCK_FREQ, BAUD_RATE);
    localparam int CW  = $clog2(SYM);
    localparam logic [CW-1:0] SYM_LAST = CW'(SYM - 1);
    localparam logic [CW-1:0] SMP_LAST = CW'(SMP - 1);

    logic                 rx_s;
    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    sync_2ff #(
        .WIDTH    (1),
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .rst_n(rst),
        .d    (serial_in),
        .q    (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        if (valid_q && data_out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d   = S_START;
                    clk_cnt_d = '0;
                end
            end
            S_START: begin
                if (clk_cnt_q == SMP_LAST) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        clk_cnt_d = '0;
                        bit_cnt_d = '0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == SYM_LAST) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    clk_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (clk_cnt_q == SYM_LAST) begin
                    state_d   = S_IDLE;
                    clk_cnt_d = '0;
                    // A bad stop bit drops the byte without touching the holding register.
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end else if (valid_q && !data_out_ready) begin
                        ovr_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign framing_error  = ferr_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level reference model with
// a per-cycle compare process, directed scenarios and random frames.
module tb_uart_receiver;

    localparam int CLK_HZ = 5_000_000;
    localparam int BAUD   = 115_200;
    localparam int SYM    = CLK_HZ / BAUD;
    localparam int SMP    = SYM / 2;
    localparam int LAT    = 3 + SMP + 9 * SYM;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       framing_error;
    logic       overrun;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int exp_fe = 0, exp_ovr = 0, obs_fe = 0, obs_ovr = 0;
    int rise_cyc = -1;
    int last_fall = 0;
    logic [7:0] exp_q[$];
    logic [7:0] hs_log[$];
    logic       v_prev = 1'b0, r_prev = 1'b0;
    logic [7:0] d_prev = 8'h00;

    uart_receiver #(
        .CPU_CLOCK_FREQ(CLK_HZ),
        .BAUD_RATE     (BAUD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame-level model: the outcome of a frame is decided when its stop bit
    // goes out, from the stop level, the ready policy and whether a byte is held.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
        serial_in = 1'b0;
        last_fall = cyc;
        cycles(SYM);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            cycles(SYM);
        end
        if (!stop_ok) exp_fe++;
        else if (!data_out_ready && exp_q.size() > 0) exp_ovr++;
        else exp_q.push_back(b);
        serial_in = stop_ok;
        cycles(stop_ok ? SYM : SYM - 5);
        serial_in = 1'b1;
        cycles(gap);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            v_prev = 1'b0;
            r_prev = 1'b0;
        end else begin
            if (framing_error) obs_fe++;
            if (overrun) obs_ovr++;
            if (framing_error || overrun)
                chk("fe_ovr_exclusive", {31'b0, framing_error & overrun}, 32'd0);
            if (data_out_valid && !v_prev) rise_cyc = cyc;
            if (v_prev && !r_prev && data_out_valid)
                chk("hold_stable", {24'b0, data_out}, {24'b0, d_prev});
            if (data_out_valid && data_out_ready) begin
                hs_log.push_back(data_out);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL handshake: got %02h with no byte expected", data_out);
                end else begin
                    chk("handshake_byte", {24'b0, data_out}, {24'b0, exp_q.pop_front()});
                end
            end
            v_prev = data_out_valid;
            r_prev = data_out_ready;
            d_prev = data_out;
        end
    end

    initial begin
        #(90_000 * 10);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, {24'b0, data_out}, 32'd0);
        chk({tag, "_valid"}, {31'b0, data_out_valid}, 32'd0);
        chk({tag, "_fe"}, {31'b0, framing_error}, 32'd0);
        chk({tag, "_ovr"}, {31'b0, overrun}, 32'd0);
    endtask

    initial begin
        int d, n0, fe0;
        logic [7:0] b;
        bit ok;
        cycles(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        cycles(5);

        // Single frame, latency and content
        data_out_ready = 1'b1;
        rise_cyc = -1;
        n0 = hs_log.size();
        send_frame(8'hA5, 1'b1, 20);
        d = rise_cyc - last_fall;
        vectors++;
        if (rise_cyc < 0 || d < LAT - 2 || d > LAT + 2) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles, wanted %0d..%0d", d, LAT - 2, LAT + 2);
        end
        chk("a5_count", hs_log.size() - n0, 32'd1);
        if (hs_log.size() > n0) chk("a5_byte", {24'b0, hs_log[n0]}, 32'hA5);

        // Short start glitch is rejected silently
        n0 = hs_log.size();
        fe0 = obs_fe + obs_ovr;
        serial_in = 1'b0;
        cycles(SMP / 2);
        serial_in = 1'b1;
        cycles(5000);
        chk("glitch_no_byte", hs_log.size() - n0, 32'd0);
        chk("glitch_no_err", obs_fe + obs_ovr - fe0, 32'd0);

        // Framing error then recovery
        fe0 = obs_fe;
        n0 = hs_log.size();
        send_frame(8'h3C, 1'b0, 3 * SYM);
        chk("fe_pulses", obs_fe - fe0, 32'd1);
        chk("fe_no_byte", hs_log.size() - n0, 32'd0);
        send_frame(8'h55, 1'b1, 20);
        if (hs_log.size() > n0) chk("after_fe_byte", {24'b0, hs_log[n0]}, 32'h55);
        else chk("after_fe_count", hs_log.size() - n0, 32'd1);

        // Overrun with the consumer stalled
        data_out_ready = 1'b0;
        fe0 = obs_ovr;
        send_frame(8'h12, 1'b1, 10);
        send_frame(8'h34, 1'b1, 10);
        chk("ovr_pulses", obs_ovr - fe0, 32'd1);
        chk("ovr_valid", {31'b0, data_out_valid}, 32'd1);
        chk("ovr_data", {24'b0, data_out}, 32'h12);
        data_out_ready = 1'b1;
        cycles(1);
        data_out_ready = 1'b0;
        cycles(1);
        chk("drain_valid", {31'b0, data_out_valid}, 32'd0);
        chk("drain_data", {24'b0, data_out}, 32'h12);

        // Back-to-back frames
        data_out_ready = 1'b1;
        n0 = hs_log.size();
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 10);
        chk("b2b_count", hs_log.size() - n0, 32'd2);
        if (hs_log.size() >= n0 + 2) begin
            chk("b2b_first", {24'b0, hs_log[n0]}, 32'h00);
            chk("b2b_second", {24'b0, hs_log[n0+1]}, 32'hFF);
        end

        // Reset in the middle of a frame
        n0 = hs_log.size();
        serial_in = 1'b0;
        cycles(SYM);
        serial_in = 1'b1;
        cycles(SYM);
        serial_in = 1'b0;
        cycles(10);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        serial_in = 1'b1;
        cycles(5);
        rst = 1'b1;
        cycles(5);
        send_frame(8'h7E, 1'b1, 20);
        chk("rst_count", hs_log.size() - n0, 32'd1);
        if (hs_log.size() > n0) chk("rst_byte", {24'b0, hs_log[n0]}, 32'h7E);

        // Random frames, stop levels, ready policy and gaps
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            data_out_ready = 1'($urandom_range(0, 1));
            send_frame(b, ok, ok ? $urandom_range(0, 30) : 3 * SYM);
        end
        data_out_ready = 1'b1;
        cycles(20);
        chk("total_fe", obs_fe, exp_fe);
        chk("total_ovr", obs_ovr, exp_ovr);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
